mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences and shares the single unified memory port between the Fetch-stage instruction read and the Memory-stage data load/store of the pipelined ARM core. Grants one requester at a time, runs the request/acknowledge handshake with a variable-latency memory and returns registered read data. Produces per-stage memory stall requests that the hazard unit ORs into its StallF/StallD/StallM/FlushE logic.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 64, busy cycles without MemAck before error; used only with MEMARB_TIMEOUT_EN
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- InstrReqF  in  1  fetch request; held stable while MemStallF=1
- PCF  in  ADDR_W  fetch address
- InstrRdF  out  DATA_W  registered instruction word
- InstrValidF  out  1  one-cycle pulse: InstrRdF valid
- DataReqM  in  1  load or store in Memory stage; held stable while MemStallM=1
- DataWeM  in  1  1 = store
- ALUOutM  in  ADDR_W  data address
- WriteDataM  in  DATA_W  store data
- ReadDataM  out  DATA_W  registered load data
- DataValidM  out  1  one-cycle pulse: data access complete
- MemStallF  out  1  = InstrReqF & ~InstrValidF
- MemStallM  out  1  = DataReqM & ~DataValidM
- MemReq  out  1  memory request, held until MemAck
- MemWe  out  1  memory write enable
- MemAddr  out  ADDR_W  registered memory address
- MemWData  out  DATA_W  registered write data
- MemRData  in  DATA_W  read data, valid with MemAck
- MemAck  in  1  one-cycle completion from memory
- MemErr  out  1  sticky timeout error (0 when feature compiled out)

## Operation
- States: IDLE, IFETCH, DACCESS, ERROR (ERROR only with MEMARB_TIMEOUT_EN).
- IDLE: if DataReqM & ~DataValidM → latch ALUOutM/WriteDataM/DataWeM, go DACCESS; else if InstrReqF & ~InstrValidF → latch PCF, MemWe=0, go IFETCH; else stay. Data always wins (older instruction).
- IFETCH/DACCESS: MemReq=1; MemAddr/MemWe/MemWData stable. On MemAck: latch MemRData into InstrRdF (IFETCH) or ReadDataM (DACCESS load), set matching valid for next cycle, go IDLE.
- Store: DataValidM pulses; ReadDataM keeps prior value.
- MemAck in IDLE or ERROR ignored.
- Request inputs changing while not in IDLE are ignored until return to IDLE.
- Reset: state IDLE; MemReq, MemWe, InstrValidF, DataValidM, MemErr = 0; MemAddr, MemWData, InstrRdF, ReadDataM = 0. Reset during a busy state abandons the transaction; a later MemAck is ignored.

## Timing
- Cycle 0: request seen in IDLE. Cycle 1: MemReq=1. Ack in cycle k≥1 → valid pulse and data in cycle k+1, state IDLE.
- Minimum request-to-valid latency 2 cycles; every transaction has exactly one IDLE turnaround cycle (the valid cycle), in which the completed requester is not re-granted.
- Back-to-back: fetch pending behind a data access is granted in the valid cycle of that access (its own valid is low), MemReq rises the cycle after.
- Stall outputs combinational from inputs and registered valids; no other combinational paths to memory side.

## Configuration
- MEMARB_TIMEOUT_EN defined: counter cleared on entering IFETCH/DACCESS, increments each busy cycle; reaching TIMEOUT_CYCLES without MemAck → ERROR: MemReq=0, MemErr=1 sticky, no valids ever, stalls remain asserted; exit only by reset. Ack in the same cycle the limit is reached wins (normal completion).
- Not defined: no counter, no ERROR state, MemErr tied 0, waits indefinitely.

## Structure
- memarb_pkg: state enum (IDLE, IFETCH, DACCESS, ERROR), default TIMEOUT_CYCLES, grant encoding constants.
- Sub-module mem_timeout_ctr (clear, enable, expired), instantiated only under MEMARB_TIMEOUT_EN.

## Test plan
- Fetch only, PCF=0x0000_0010, MemAck in cycle 1 with 0xE3A0_1005 → InstrValidF cycle 2, InstrRdF=0xE3A0_1005, MemStallF high cycles 0–1.
- Simultaneous InstrReqF (PCF=0x20) and load (ALUOutM=0x100): MemAddr=0x100 first, DataValidM, then MemAddr=0x20 next; MemStallF held until InstrValidF.
- Store ALUOutM=0x200, WriteDataM=0xDEAD_BEEF, ack after 3 wait cycles → MemWe=1, data stable all busy cycles, DataValidM cycle 5, ReadDataM unchanged.
- Reset asserted in DACCESS, MemAck arrives cycle after reset release → state IDLE, no valid pulse, all outputs zero.
- MEMARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → MemReq drops after 4 busy cycles, MemErr=1 until reset, MemStallF/MemStallM stay high.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, grant codes
// and the fixed data-over-fetch priority rule.
package memarb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IFETCH  = 2'd1,
      DACCESS = 2'd2,
      ERROR   = 2'd3
   } arb_state_e;

   localparam int TIMEOUT_CYCLES_DEF = 64;

   localparam logic [1:0] GNT_NONE  = 2'd0;
   localparam logic [1:0] GNT_FETCH = 2'd1;
   localparam logic [1:0] GNT_DATA  = 2'd2;

   // The Memory-stage access is the older instruction, so it always wins.
   function automatic logic [1:0] arb_grant(input logic data_pend, input logic fetch_pend);
      logic [1:0] g;
      g = GNT_NONE;
      if (data_pend) begin
         g = GNT_DATA;
      end else if (fetch_pend) begin
         g = GNT_FETCH;
      end
      return g;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// Busy-cycle watchdog: cleared when a transaction starts, flags the busy cycle
// in which LIMIT cycles have elapsed without completion.
module mem_timeout_ctr #(
   parameter int LIMIT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != CW'(LIMIT))) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = enable && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and Memory-stage accesses.
// Optional busy-timeout watchdog with sticky error: define MEMARB_TIMEOUT_EN.
module mem_port_arbiter
   import memarb_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              InstrReqF,
   input  logic [ADDR_W-1:0] PCF,
   output logic [DATA_W-1:0] InstrRdF,
   output logic              InstrValidF,
   input  logic              DataReqM,
   input  logic              DataWeM,
   input  logic [ADDR_W-1:0] ALUOutM,
   input  logic [DATA_W-1:0] WriteDataM,
   output logic [DATA_W-1:0] ReadDataM,
   output logic              DataValidM,
   output logic              MemStallF,
   output logic              MemStallM,
   output logic              MemReq,
   output logic              MemWe,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWData,
   input  logic [DATA_W-1:0] MemRData,
   input  logic              MemAck,
   output logic              MemErr
);

   arb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] irdata_q, irdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ivld_q, ivld_d;
   logic              dvld_q, dvld_d;
   logic              ctr_clear;
   logic [1:0]        gnt;

   // A requester is not re-granted in its own valid (turnaround) cycle.
   assign gnt = arb_grant(DataReqM & ~dvld_q, InstrReqF & ~ivld_q);

`ifdef MEMARB_TIMEOUT_EN
   logic err_q, err_d;
   logic expired;

   mem_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (ctr_clear),
      .enable  (MemReq),
      .expired (expired)
   );
`else
   localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = we_q;
      irdata_d  = irdata_q;
      rdata_d   = rdata_q;
      ivld_d    = 1'b0;
      dvld_d    = 1'b0;
      ctr_clear = 1'b0;
`ifdef MEMARB_TIMEOUT_EN
      err_d     = err_q;
`endif
      case (state_q)
         IDLE: begin
            case (gnt)
               GNT_DATA: begin
                  addr_d    = ALUOutM;
                  wdata_d   = WriteDataM;
                  we_d      = DataWeM;
                  ctr_clear = 1'b1;
                  state_d   = DACCESS;
               end
               GNT_FETCH: begin
                  addr_d    = PCF;
                  we_d      = 1'b0;
                  ctr_clear = 1'b1;
                  state_d   = IFETCH;
               end
               default: ;
            endcase
         end
         IFETCH, DACCESS: begin
            // An ack in the same cycle the watchdog expires still completes.
            if (MemAck) begin
               if (state_q == IFETCH) begin
                  irdata_d = MemRData;
                  ivld_d   = 1'b1;
               end else begin
                  dvld_d = 1'b1;
                  if (!we_q) begin
                     rdata_d = MemRData;
                  end
               end
               state_d = IDLE;
`ifdef MEMARB_TIMEOUT_EN
            end else if (expired) begin
               err_d   = 1'b1;
               state_d = ERROR;
`endif
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         irdata_q <= '0;
         rdata_q  <= '0;
         ivld_q   <= 1'b0;
         dvld_q   <= 1'b0;
`ifdef MEMARB_TIMEOUT_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         irdata_q <= irdata_d;
         rdata_q  <= rdata_d;
         ivld_q   <= ivld_d;
         dvld_q   <= dvld_d;
`ifdef MEMARB_TIMEOUT_EN
         err_q    <= err_d;
`endif
      end
   end

   assign MemReq      = (state_q == IFETCH) || (state_q == DACCESS);
   assign MemWe       = we_q;
   assign MemAddr     = addr_q;
   assign MemWData    = wdata_q;
   assign InstrRdF    = irdata_q;
   assign ReadDataM   = rdata_q;
   assign InstrValidF = ivld_q;
   assign DataValidM  = dvld_q;
   assign MemStallF   = InstrReqF & ~ivld_q;
   assign MemStallM   = DataReqM & ~dvld_q;
`ifdef MEMARB_TIMEOUT_EN
   assign MemErr      = err_q;
`else
   assign MemErr      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
`ifdef MEMARB_TIMEOUT_EN
   localparam int TB_TO = 4;
`else
   localparam int TB_TO = 64;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          InstrReqF, DataReqM, DataWeM, MemAck;
   logic [AW-1:0] PCF, ALUOutM;
   logic [DW-1:0] WriteDataM, MemRData;
   logic [DW-1:0] InstrRdF, ReadDataM, MemWData;
   logic [AW-1:0] MemAddr;
   logic          InstrValidF, DataValidM, MemStallF, MemStallM;
   logic          MemReq, MemWe, MemErr;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TB_TO)) dut (
      .clk(clk), .reset(reset),
      .InstrReqF(InstrReqF), .PCF(PCF), .InstrRdF(InstrRdF), .InstrValidF(InstrValidF),
      .DataReqM(DataReqM), .DataWeM(DataWeM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
      .ReadDataM(ReadDataM), .DataValidM(DataValidM),
      .MemStallF(MemStallF), .MemStallM(MemStallM),
      .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
      .MemRData(MemRData), .MemAck(MemAck), .MemErr(MemErr)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level view: one outstanding access (or none), what it carries,
   // and what the requesters were handed back last cycle.
   bit            m_act, m_isdata, m_we, m_ivld, m_dvld, m_err;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_irdata, m_rdata;
   int            m_busy;

   always @(posedge clk) begin : model
      bit pi, pd;
      pi = m_ivld;
      pd = m_dvld;
      m_ivld = 1'b0;
      m_dvld = 1'b0;
      if (reset) begin
         m_act = 0; m_isdata = 0; m_we = 0; m_err = 0; m_busy = 0;
         m_addr = '0; m_wdata = '0; m_irdata = '0; m_rdata = '0;
      end else if (m_err) begin
         m_act = 0;
      end else if (m_act) begin
         if (MemAck) begin
            if (m_isdata) begin
               m_dvld = 1'b1;
               if (!m_we) m_rdata = MemRData;
            end else begin
               m_ivld   = 1'b1;
               m_irdata = MemRData;
            end
            m_act = 0;
         end else begin
            m_busy++;
`ifdef MEMARB_TIMEOUT_EN
            if (m_busy == TB_TO) begin
               m_act = 0;
               m_err = 1;
            end
`endif
         end
      end else if (DataReqM && !pd) begin
         m_act = 1; m_isdata = 1; m_busy = 0;
         m_addr = ALUOutM; m_wdata = WriteDataM; m_we = DataWeM;
      end else if (InstrReqF && !pi) begin
         m_act = 1; m_isdata = 0; m_busy = 0;
         m_addr = PCF; m_we = 0;
      end
   end

   always @(negedge clk) begin : compare
      chk("MemReq", MemReq, m_act);
      chk("MemWe", MemWe, m_we);
      chk("MemAddr", MemAddr, m_addr);
      chk("MemWData", MemWData, m_wdata);
      chk("InstrRdF", InstrRdF, m_irdata);
      chk("ReadDataM", ReadDataM, m_rdata);
      chk("InstrValidF", InstrValidF, m_ivld);
      chk("DataValidM", DataValidM, m_dvld);
      chk("MemStallF", MemStallF, InstrReqF & ~m_ivld);
      chk("MemStallM", MemStallM, DataReqM & ~m_dvld);
      chk("MemErr", MemErr, m_err);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   bit f_done, d_done;
   int mwait;

   initial begin
      reset = 1; InstrReqF = 0; DataReqM = 0; DataWeM = 0; MemAck = 0;
      PCF = '0; ALUOutM = '0; WriteDataM = '0; MemRData = '0;
      cyc(); cyc();
      smp();
      chk("rst MemReq", MemReq, 0);
      chk("rst MemAddr", MemAddr, 0);
      chk("rst InstrValidF", InstrValidF, 0);
      chk("rst ReadDataM", ReadDataM, 0);
      cyc(); reset = 0;

      // Fetch only, ack in cycle 1
      cyc(); InstrReqF = 1; PCF = 32'h10;
      smp(); chk("t1 stallF c0", MemStallF, 1); chk("t1 req c0", MemReq, 0);
      cyc(); MemAck = 1; MemRData = 32'hE3A0_1005;
      smp(); chk("t1 req c1", MemReq, 1); chk("t1 addr c1", MemAddr, 32'h10); chk("t1 stallF c1", MemStallF, 1);
      cyc(); MemAck = 0;
      smp(); chk("t1 ivld c2", InstrValidF, 1); chk("t1 rd c2", InstrRdF, 32'hE3A0_1005);
      chk("t1 stallF c2", MemStallF, 0);

      // Simultaneous fetch and load: data first
      cyc(); InstrReqF = 1; PCF = 32'h20; DataReqM = 1; DataWeM = 0; ALUOutM = 32'h100;
      WriteDataM = 32'h1111_1111;
      smp(); chk("t2 stallM c0", MemStallM, 1);
      cyc(); MemAck = 1; MemRData = 32'h0000_1234;
      smp(); chk("t2 addr d", MemAddr, 32'h100); chk("t2 we d", MemWe, 0);
      cyc(); MemAck = 0;
      smp(); chk("t2 dvld", DataValidM, 1); chk("t2 rdata", ReadDataM, 32'h1234);
      chk("t2 stallF held", MemStallF, 1);
      cyc(); DataReqM = 0; MemAck = 1; MemRData = 32'h0000_5678;
      smp(); chk("t2 req f", MemReq, 1); chk("t2 addr f", MemAddr, 32'h20);
      cyc(); MemAck = 0;
      smp(); chk("t2 ivld", InstrValidF, 1); chk("t2 rd", InstrRdF, 32'h5678);

      // Store with three wait cycles
      cyc(); InstrReqF = 0; DataReqM = 1; DataWeM = 1; ALUOutM = 32'h200; WriteDataM = 32'hDEAD_BEEF;
      for (int i = 1; i <= 4; i++) begin
         cyc(); MemAck = (i == 4); MemRData = 32'hBAD0_BAD0;
         smp(); chk("t3 req", MemReq, 1); chk("t3 we", MemWe, 1);
         chk("t3 addr", MemAddr, 32'h200); chk("t3 wdata", MemWData, 32'hDEAD_BEEF);
      end
      cyc(); MemAck = 0;
      smp(); chk("t3 dvld c5", DataValidM, 1); chk("t3 rdata kept", ReadDataM, 32'h1234);

      // Reset abandons a load; a late ack is ignored
      cyc(); DataWeM = 0; ALUOutM = 32'h300; WriteDataM = 32'h0;
      cyc(); smp(); chk("t4 busy", MemReq, 1);
      cyc(); reset = 1; DataReqM = 0;
      cyc(); reset = 0;
      cyc(); MemAck = 1; MemRData = 32'hCAFE;
      cyc(); MemAck = 0;
      smp(); chk("t4 dvld", DataValidM, 0); chk("t4 rdata", ReadDataM, 0); chk("t4 req", MemReq, 0);
      chk("t4 addr", MemAddr, 0); chk("t4 wdata", MemWData, 0); chk("t4 ird", InstrRdF, 0);

      // Randomized traffic with a variable-latency memory and stray acks
      f_done = 0; d_done = 0; mwait = $urandom_range(0, 3);
      for (int n = 0; n < 3000; n++) begin
         cyc();
         reset = ($urandom_range(0, 299) == 0);
         if (!InstrReqF || f_done) begin
            InstrReqF = $urandom_range(0, 1);
            PCF = $urandom & ~32'h3;
         end
         if (!DataReqM || d_done) begin
            DataReqM = $urandom_range(0, 1);
            DataWeM = $urandom_range(0, 1);
            ALUOutM = $urandom;
            WriteDataM = $urandom;
         end
         if (MemReq) begin
            if (mwait == 0) begin
               MemAck = 1; MemRData = $urandom; mwait = $urandom_range(0, 3);
            end else begin
               MemAck = 0; mwait--;
            end
         end else begin
            MemAck = ($urandom_range(0, 7) == 0);
            MemRData = $urandom;
         end
         smp();
         f_done = InstrValidF;
         d_done = DataValidM;
      end
      cyc(); reset = 1; InstrReqF = 0; DataReqM = 0; MemAck = 0;
      cyc(); reset = 0;

`ifdef MEMARB_TIMEOUT_EN
      // No ack: error after TB_TO busy cycles, sticky until reset
      cyc(); InstrReqF = 1; PCF = 32'h40; DataReqM = 1; DataWeM = 0; ALUOutM = 32'h400;
      for (int i = 1; i <= TB_TO; i++) begin
         cyc(); smp(); chk("to busy req", MemReq, 1);
      end
      cyc(); smp();
      chk("to req drop", MemReq, 0); chk("to err", MemErr, 1);
      chk("to stallF", MemStallF, 1); chk("to stallM", MemStallM, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(); MemAck = 1;
         smp(); chk("to err sticky", MemErr, 1); chk("to no dvld", DataValidM, 0);
      end
      cyc(); reset = 1; InstrReqF = 0; DataReqM = 0; MemAck = 0;
      cyc(); reset = 0;
      smp(); chk("to err cleared", MemErr, 0);
`endif

      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
